writeback_pipe: RTL and testbench

Result staging and writeback block for the dual-issue SPU datapath, sitting between the even/odd execution units and the Register File. It accepts finished results from either pipe together with the unit's remaining latency and holds them in per-pipe shift slots. It retires each result on the Register File write port after the correct number of cycles. It also answers forwarding lookups against every in-flight result so the operand path can bypass the Register File.

---
 rtl/writeback_pipe_if.sv | 52 +++++
 rtl/writeback_pipe.sv | 136 +++++++++++++
 tb/tb_writeback_pipe.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_pipe_if.sv
// Result and lookup bundle between the execution units, the writeback stager and the Register File.
// There is no backpressure: a result with reg_write=1 is consumed on the edge it is presented; it is
// either staged or dropped, and a drop is reported on collision_* in the following cycle.
interface writeback_pipe_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0] rt_addr_even_input;
    logic [ADDR_W-1:0] rt_addr_odd_input;
    logic [DATA_W-1:0] rt_even_input;
    logic [DATA_W-1:0] rt_odd_input;
    logic              reg_write_even_input;
    logic              reg_write_odd_input;
    logic [2:0]        latency_even_input;
    logic [2:0]        latency_odd_input;
    logic              flush;
    logic [ADDR_W-1:0] fwd_addr_a;
    logic [ADDR_W-1:0] fwd_addr_b;

    logic [ADDR_W-1:0] rt_addr_even_output;
    logic [ADDR_W-1:0] rt_addr_odd_output;
    logic [DATA_W-1:0] rt_even_output;
    logic [DATA_W-1:0] rt_odd_output;
    logic              reg_write_even_output;
    logic              reg_write_odd_output;
    logic              fwd_hit_a;
    logic              fwd_hit_b;
    logic [DATA_W-1:0] fwd_data_a;
    logic [DATA_W-1:0] fwd_data_b;
    logic              collision_even;
    logic              collision_odd;

    // Execution-unit / operand-path side.
    modport master (
        output rt_addr_even_input, rt_addr_odd_input, rt_even_input, rt_odd_input,
        output reg_write_even_input, reg_write_odd_input,
        output latency_even_input, latency_odd_input, flush, fwd_addr_a, fwd_addr_b,
        input  rt_addr_even_output, rt_addr_odd_output, rt_even_output, rt_odd_output,
        input  reg_write_even_output, reg_write_odd_output,
        input  fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b, collision_even, collision_odd
    );

    // Writeback stager side.
    modport slave (
        input  rt_addr_even_input, rt_addr_odd_input, rt_even_input, rt_odd_input,
        input  reg_write_even_input, reg_write_odd_input,
        input  latency_even_input, latency_odd_input, flush, fwd_addr_a, fwd_addr_b,
        output rt_addr_even_output, rt_addr_odd_output, rt_even_output, rt_odd_output,
        output reg_write_even_output, reg_write_odd_output,
        output fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b, collision_even, collision_odd
    );
endinterface

// File: rtl/writeback_pipe.sv
// Dual-pipe result staging: per-pipe shift slots retire results to the Register File after their
// remaining latency, and every in-flight result is visible to two combinational forwarding lookups.
module writeback_pipe #(
    parameter int DEPTH  = 7,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128
) (
    input  logic             clock,
    input  logic             reset,
    writeback_pipe_if.slave  bus
);
    // Index 0 is the even pipe, index 1 the odd pipe; slot 1 is the one presented for writeback.
    logic              r_v     [2][1:DEPTH];
    logic [ADDR_W-1:0] r_a     [2][1:DEPTH];
    logic [DATA_W-1:0] r_d     [2][1:DEPTH];
    logic              r_coll  [2];

    logic              w_nv    [2][1:DEPTH];
    logic [ADDR_W-1:0] w_na    [2][1:DEPTH];
    logic [DATA_W-1:0] w_nd    [2][1:DEPTH];
    logic              w_ncoll [2];
    logic              w_slot_hit;

    logic              w_in_we   [2];
    logic [2:0]        w_in_lat  [2];
    logic [ADDR_W-1:0] w_in_addr [2];
    logic [DATA_W-1:0] w_in_data [2];

    logic [ADDR_W-1:0] w_fwd_addr [2];
    logic              w_fwd_hit  [2];
    logic [DATA_W-1:0] w_fwd_data [2];

    assign w_in_we[0]   = bus.reg_write_even_input;
    assign w_in_we[1]   = bus.reg_write_odd_input;
    assign w_in_lat[0]  = bus.latency_even_input;
    assign w_in_lat[1]  = bus.latency_odd_input;
    assign w_in_addr[0] = bus.rt_addr_even_input;
    assign w_in_addr[1] = bus.rt_addr_odd_input;
    assign w_in_data[0] = bus.rt_even_input;
    assign w_in_data[1] = bus.rt_odd_input;
    assign w_fwd_addr[0] = bus.fwd_addr_a;
    assign w_fwd_addr[1] = bus.fwd_addr_b;

    // Shift first, then insert; an occupied target slot keeps the older result.
    always_comb begin
        w_slot_hit = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i < DEPTH; i++) begin
                w_nv[p][i] = r_v[p][i+1];
                w_na[p][i] = r_a[p][i+1];
                w_nd[p][i] = r_d[p][i+1];
            end
            w_nv[p][DEPTH] = 1'b0;
            w_na[p][DEPTH] = '0;
            w_nd[p][DEPTH] = '0;
            w_ncoll[p]     = 1'b0;
            w_slot_hit     = 1'b0;
            if (w_in_we[p]) begin
                for (int i = 1; i <= DEPTH; i++) begin
                    if (w_in_lat[p] == 3'(i)) begin
                        w_slot_hit = 1'b1;
                        if (w_nv[p][i]) begin
                            w_ncoll[p] = 1'b1;
                        end else begin
                            w_nv[p][i] = 1'b1;
                            w_na[p][i] = w_in_addr[p];
                            w_nd[p][i] = w_in_data[p];
                        end
                    end
                end
                // Latency 0 or beyond DEPTH never matches a slot.
                if (!w_slot_hit) begin
                    w_ncoll[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                r_coll[p] <= 1'b0;
                for (int i = 1; i <= DEPTH; i++) begin
                    r_v[p][i] <= 1'b0;
                    r_a[p][i] <= '0;
                    r_d[p][i] <= '0;
                end
            end
        end else if (bus.flush) begin
            for (int p = 0; p < 2; p++) begin
                r_coll[p] <= 1'b0;
                for (int i = 1; i <= DEPTH; i++) begin
                    r_v[p][i] <= 1'b0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_coll[p] <= w_ncoll[p];
                for (int i = 1; i <= DEPTH; i++) begin
                    r_v[p][i] <= w_nv[p][i];
                    r_a[p][i] <= w_na[p][i];
                    r_d[p][i] <= w_nd[p][i];
                end
            end
        end
    end

    // Later matches override earlier ones: higher slot wins, and odd wins within a slot.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_fwd_hit[k]  = 1'b0;
            w_fwd_data[k] = '0;
            for (int i = 1; i <= DEPTH; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (r_v[p][i] && (r_a[p][i] == w_fwd_addr[k])) begin
                        w_fwd_hit[k]  = 1'b1;
                        w_fwd_data[k] = r_d[p][i];
                    end
                end
            end
        end
    end

    assign bus.reg_write_even_output = r_v[0][1];
    assign bus.reg_write_odd_output  = r_v[1][1];
    assign bus.rt_addr_even_output   = r_v[0][1] ? r_a[0][1] : '0;
    assign bus.rt_addr_odd_output    = r_v[1][1] ? r_a[1][1] : '0;
    assign bus.rt_even_output        = r_v[0][1] ? r_d[0][1] : '0;
    assign bus.rt_odd_output         = r_v[1][1] ? r_d[1][1] : '0;
    assign bus.collision_even        = r_coll[0];
    assign bus.collision_odd         = r_coll[1];
    assign bus.fwd_hit_a             = w_fwd_hit[0];
    assign bus.fwd_hit_b             = w_fwd_hit[1];
    assign bus.fwd_data_a            = w_fwd_data[0];
    assign bus.fwd_data_b            = w_fwd_data[1];
endmodule

// File: tb/tb_writeback_pipe.sv
// Bench for writeback_pipe: results are scheduled by their due cycle in an expected queue and
// compared against the write port, collision pulses and forwarding lookups every cycle.
module tb_writeback_pipe;
    localparam int DEPTH  = 6;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 128;

    typedef struct packed {
        int                due;
        logic              pipe;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];
    logic exp_coll [2];

    writeback_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    writeback_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic exp_fwd(input logic [ADDR_W-1:0] fa, output logic hit,
                           output logic [DATA_W-1:0] data);
        int best;
        best = -1;
        hit  = 1'b0;
        data = '0;
        foreach (exp_q[k]) begin
            if (exp_q[k].due >= cyc && exp_q[k].addr == fa &&
                (exp_q[k].due > best || (exp_q[k].due == best && exp_q[k].pipe))) begin
                best = exp_q[k].due;
                hit  = 1'b1;
                data = exp_q[k].data;
            end
        end
    endtask

    task automatic check_outputs();
        logic              ew [2];
        logic [ADDR_W-1:0] ea [2];
        logic [DATA_W-1:0] ed [2];
        logic              fh;
        logic [DATA_W-1:0] fd;
        for (int p = 0; p < 2; p++) begin
            ew[p] = 1'b0;
            ea[p] = '0;
            ed[p] = '0;
        end
        foreach (exp_q[k]) begin
            if (exp_q[k].due == cyc) begin
                ew[exp_q[k].pipe] = 1'b1;
                ea[exp_q[k].pipe] = exp_q[k].addr;
                ed[exp_q[k].pipe] = exp_q[k].data;
            end
        end
        check_val("we_even",   bus.reg_write_even_output, ew[0]);
        check_val("addr_even", bus.rt_addr_even_output,   ea[0]);
        check_val("data_even", bus.rt_even_output,        ed[0]);
        check_val("we_odd",    bus.reg_write_odd_output,  ew[1]);
        check_val("addr_odd",  bus.rt_addr_odd_output,    ea[1]);
        check_val("data_odd",  bus.rt_odd_output,         ed[1]);
        check_val("coll_even", bus.collision_even,        exp_coll[0]);
        check_val("coll_odd",  bus.collision_odd,         exp_coll[1]);
        exp_fwd(bus.fwd_addr_a, fh, fd);
        check_val("fwd_hit_a",  bus.fwd_hit_a,  fh);
        check_val("fwd_data_a", bus.fwd_data_a, fd);
        exp_fwd(bus.fwd_addr_b, fh, fd);
        check_val("fwd_hit_b",  bus.fwd_hit_b,  fh);
        check_val("fwd_data_b", bus.fwd_data_b, fd);
    endtask

    // Model the coming edge from the current inputs, then clock and compare.
    task automatic tick();
        logic              we  [2];
        logic [2:0]        lat [2];
        logic [ADDR_W-1:0] ad  [2];
        logic [DATA_W-1:0] dt  [2];
        int                due;
        logic              busy;
        we[0] = bus.reg_write_even_input;  we[1] = bus.reg_write_odd_input;
        lat[0] = bus.latency_even_input;   lat[1] = bus.latency_odd_input;
        ad[0] = bus.rt_addr_even_input;    ad[1] = bus.rt_addr_odd_input;
        dt[0] = bus.rt_even_input;         dt[1] = bus.rt_odd_input;
        for (int k = exp_q.size() - 1; k >= 0; k--)
            if (exp_q[k].due <= cyc) exp_q.delete(k);
        exp_coll[0] = 1'b0;
        exp_coll[1] = 1'b0;
        if (!reset || bus.flush) begin
            exp_q.delete();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (we[p]) begin
                    if (lat[p] == 3'd0 || int'(lat[p]) > DEPTH) begin
                        exp_coll[p] = 1'b1;
                    end else begin
                        due  = cyc + int'(lat[p]);
                        busy = 1'b0;
                        foreach (exp_q[k])
                            if (exp_q[k].pipe == 1'(p) && exp_q[k].due == due) busy = 1'b1;
                        if (busy) exp_coll[p] = 1'b1;
                        else exp_q.push_back('{due, 1'(p), ad[p], dt[p]});
                    end
                end
            end
        end
        @(posedge clock);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic issue(input logic we_e, input logic [ADDR_W-1:0] a_e,
                         input logic [DATA_W-1:0] d_e, input logic [2:0] l_e,
                         input logic we_o, input logic [ADDR_W-1:0] a_o,
                         input logic [DATA_W-1:0] d_o, input logic [2:0] l_o,
                         input logic fl);
        bus.reg_write_even_input = we_e;
        bus.rt_addr_even_input   = a_e;
        bus.rt_even_input        = d_e;
        bus.latency_even_input   = l_e;
        bus.reg_write_odd_input  = we_o;
        bus.rt_addr_odd_input    = a_o;
        bus.rt_odd_input         = d_o;
        bus.latency_odd_input    = l_o;
        bus.flush                = fl;
        tick();
        bus.reg_write_even_input = 1'b0;
        bus.reg_write_odd_input  = 1'b0;
        bus.flush                = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        exp_coll[0] = 1'b0;
        exp_coll[1] = 1'b0;
        reset = 1'b0;
        bus.reg_write_even_input = 1'b0;
        bus.reg_write_odd_input  = 1'b0;
        bus.rt_addr_even_input   = '0;
        bus.rt_addr_odd_input    = '0;
        bus.rt_even_input        = '0;
        bus.rt_odd_input         = '0;
        bus.latency_even_input   = '0;
        bus.latency_odd_input    = '0;
        bus.flush                = 1'b0;
        bus.fwd_addr_a           = 7'd5;
        bus.fwd_addr_b           = 7'd0;

        // Inputs presented while in reset must not be captured.
        #1;
        check_outputs();
        issue(1, 7'd0, 128'hDEAD, 3'd1, 1, 7'd0, 128'hBEEF, 3'd1, 0);
        idle(2);
        reset = 1'b1;

        // Single even result, latency 3.
        issue(1, 7'd5, 128'h3F8A_0000_1111_2222_3333_4444_5555_66C4, 3'd3, 0, 0, 0, 0, 0);
        idle(4);

        // Same address, same latency on both pipes: odd forwarded.
        issue(1, 7'd5, 128'hE0E0, 3'd2, 1, 7'd5, 128'h0D0D, 3'd2, 0);
        idle(3);

        // Older, longer-latency result at a higher slot shadows the newer one.
        bus.fwd_addr_a = 7'd7;
        issue(1, 7'd7, 128'hA11, 3'd4, 0, 0, 0, 0, 0);
        issue(1, 7'd7, 128'hB22, 3'd2, 0, 0, 0, 0, 0);
        idle(5);

        // Second result lands on the occupied slot and is dropped.
        issue(1, 7'd9, 128'hC33, 3'd3, 0, 0, 0, 0, 0);
        issue(1, 7'd10, 128'hC44, 3'd2, 0, 0, 0, 0, 0);
        idle(4);

        // Illegal latencies on both pipes.
        issue(1, 7'd3, 128'h1, 3'd0, 1, 7'd3, 128'h2, 3'd7, 0);
        idle(2);

        // Full occupancy on the odd pipe, then flush with ignored inputs.
        bus.fwd_addr_a = 7'd20;
        bus.fwd_addr_b = 7'd25;
        for (int i = 0; i < DEPTH; i++)
            issue(1, 7'(30 + i), rnd_data(), 3'(DEPTH), 1, 7'(20 + i), rnd_data(), 3'(DEPTH), 0);
        issue(1, 7'd20, 128'h55, 3'd1, 1, 7'd25, 128'h66, 3'd2, 1);
        idle(DEPTH + 1);

        // Randomised traffic with occasional flushes over a small address range.
        for (int n = 0; n < 300; n++) begin
            bus.fwd_addr_a = 7'($urandom_range(0, 7));
            bus.fwd_addr_b = 7'($urandom_range(0, 7));
            issue($urandom_range(0, 3) != 0, 7'($urandom_range(0, 7)), rnd_data(),
                  3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, 7'($urandom_range(0, 7)), rnd_data(),
                  3'($urandom_range(0, 7)),
                  $urandom_range(0, 24) == 0);
        end

        // Asynchronous reset with results in flight clears outputs immediately.
        bus.fwd_addr_a = 7'd40;
        bus.fwd_addr_b = 7'd41;
        issue(1, 7'd40, 128'h77, 3'd1, 1, 7'd41, 128'h88, 3'd3, 0);
        issue(1, 7'd41, 128'h99, 3'd2, 1, 7'd40, 128'hAA, 3'd1, 0);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        exp_coll[0] = 1'b0;
        exp_coll[1] = 1'b0;
        check_outputs();
        issue(1, 7'd40, 128'hBB, 3'd1, 1, 7'd41, 128'hCC, 3'd1, 0);
        reset = 1'b1;
        idle(2);
        issue(1, 7'd40, 128'hDD, 3'd1, 0, 0, 0, 0, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
